pbox_param: RTL and testbench

//  Parametrised predication box for a CGRA PE; next generation of the single-bit PBox.

---
 rtl/pbox_param_if.sv | 42 ++++
 rtl/pbox_param.sv | 178 +++++++++++++++++
 tb/tb_pbox_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pbox_param_if.sv
// ---------------------------------------------------------------------------
// pbox_param_if : bus bundle for the parametrised predication box.
//   Parameters NUM_STATUS and DEPTH must match the attached pbox_param.
//   master modport : drives EN_I, STATUS_I, CONTEXT_I; observes the outputs.
//   slave modport  : the pbox_param side.
//   Signals:
//     EN_I          global enable; 0 holds all state
//     STATUS_I      comparator status bits
//     CONTEXT_I     per-cycle context word (CTX_W bits)
//     REG_O         regfile[RADDR_OUT]
//     COMB_O        combinational predicate selected by OUT_SEL
//     STACK_FULL_O  snapshot stack full
//     STACK_EMPTY_O snapshot stack empty
//     ERR_O         sticky stack over/underflow
// ---------------------------------------------------------------------------
interface pbox_param_if #(
  parameter int NUM_STATUS = 4,
  parameter int DEPTH      = 8
);
  localparam int SW    = (NUM_STATUS > 1) ? $clog2(NUM_STATUS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CTX_W = 10 + SW + 4 * AW;

  logic                  EN_I;
  logic [NUM_STATUS-1:0] STATUS_I;
  logic [CTX_W-1:0]      CONTEXT_I;
  logic                  REG_O;
  logic                  COMB_O;
  logic                  STACK_FULL_O;
  logic                  STACK_EMPTY_O;
  logic                  ERR_O;

  modport master (
    output EN_I, STATUS_I, CONTEXT_I,
    input  REG_O, COMB_O, STACK_FULL_O, STACK_EMPTY_O, ERR_O
  );

  modport slave (
    input  EN_I, STATUS_I, CONTEXT_I,
    output REG_O, COMB_O, STACK_FULL_O, STACK_EMPTY_O, ERR_O
  );
endinterface

// File: rtl/pbox_param.sv
// ---------------------------------------------------------------------------
// pbox_param : parametrised predication box for a CGRA PE.
//   Selects one status bit, combines it (port A) or its inverse (port B) with
//   a stored predicate, and writes the results into a DEPTH-entry predicate
//   register file. Optional snapshot stack for nested if-conversion is built
//   only when the macro PBOX_STACK_EN is defined.
// Ports:
//   CLK_I    clock, all state on rising edge
//   RST_N_I  asynchronous reset, active low
//   bus      pbox_param_if.slave (EN_I, STATUS_I, CONTEXT_I in;
//            REG_O, COMB_O, STACK_FULL_O, STACK_EMPTY_O, ERR_O out)
// Context word, LSB first:
//   WR_EN_A, WR_EN_B, STATUS_SEL[SW], WADDR_A[AW], WADDR_B[AW],
//   RADDR_COMB[AW], RADDR_OUT[AW], OP_A[2], OP_B[2], OUT_SEL[2], STACK_OP[2]
// ---------------------------------------------------------------------------
module pbox_param #(
  parameter int NUM_STATUS  = 4,
  parameter int DEPTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  pbox_param_if.slave   bus
);
  localparam int SW    = (NUM_STATUS > 1) ? $clog2(NUM_STATUS) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CTX_W = 10 + SW + 4 * AW;

  // Field offsets inside the context word
  localparam int O_SEL  = 2;
  localparam int O_WA   = O_SEL + SW;
  localparam int O_WB   = O_WA + AW;
  localparam int O_RC   = O_WB + AW;
  localparam int O_RO   = O_RC + AW;
  localparam int O_OPA  = O_RO + AW;
  localparam int O_OPB  = O_OPA + 2;
  localparam int O_OSEL = O_OPB + 2;
  localparam int O_SOP  = O_OSEL + 2;

  typedef enum logic [1:0] {OP_BYP = 2'd0, OP_AND = 2'd1, OP_OR = 2'd2, OP_XOR = 2'd3} op_e;
  typedef enum logic [1:0] {SEL_INA = 2'd0, SEL_INB = 2'd1, SEL_REG = 2'd2, SEL_C = 2'd3} osel_e;

  function automatic logic apply_op(input logic [1:0] op, input logic x, input logic c);
    case (op_e'(op))
      OP_BYP:  apply_op = x;
      OP_AND:  apply_op = x & c;
      OP_OR:   apply_op = x | c;
      default: apply_op = x ^ c;
    endcase
  endfunction

  // Out-of-range read addresses return 0.
  function automatic logic rf_read(input logic [DEPTH-1:0] rf, input logic [AW-1:0] addr);
    rf_read = (int'(addr) < DEPTH) ? rf[addr] : 1'b0;
  endfunction

  // Context decode
  logic            wr_en_a, wr_en_b;
  logic [SW-1:0]   status_sel;
  logic [AW-1:0]   waddr_a, waddr_b, raddr_comb, raddr_out;
  logic [1:0]      op_a, op_b, out_sel;

  assign wr_en_a    = bus.CONTEXT_I[0];
  assign wr_en_b    = bus.CONTEXT_I[1];
  assign status_sel = bus.CONTEXT_I[O_SEL +: SW];
  assign waddr_a    = bus.CONTEXT_I[O_WA +: AW];
  assign waddr_b    = bus.CONTEXT_I[O_WB +: AW];
  assign raddr_comb = bus.CONTEXT_I[O_RC +: AW];
  assign raddr_out  = bus.CONTEXT_I[O_RO +: AW];
  assign op_a       = bus.CONTEXT_I[O_OPA +: 2];
  assign op_b       = bus.CONTEXT_I[O_OPB +: 2];
  assign out_sel    = bus.CONTEXT_I[O_OSEL +: 2];

  // Datapath
  logic [DEPTH-1:0] rf_q, rf_d, rf_base;
  logic             s, c, reg_out, in_a, in_b;

  assign s       = (int'(status_sel) < NUM_STATUS) ? bus.STATUS_I[status_sel] : 1'b0;
  assign c       = rf_read(rf_q, raddr_comb);
  assign reg_out = rf_read(rf_q, raddr_out);
  assign in_a    = apply_op(op_a, s, c);
  assign in_b    = apply_op(op_b, ~s, c);

  always_comb begin
    // NOTE: default first so every path assigns; a missing branch would infer a latch.
    bus.COMB_O = 1'b0;
    case (osel_e'(out_sel))
      SEL_INA: bus.COMB_O = in_a;
      SEL_INB: bus.COMB_O = in_b;
      SEL_REG: bus.COMB_O = reg_out;
      default: bus.COMB_O = c;
    endcase
  end

  assign bus.REG_O = reg_out;

`ifdef PBOX_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {ST_NOP = 2'd0, ST_PUSH = 2'd1, ST_POP = 2'd2, ST_RSV = 2'd3} stack_op_e;

  logic [DEPTH-1:0] stack_q [STACK_DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic             err_q, err_d;
  logic             full, empty, push_ok;
  logic [IW-1:0]    push_idx, top_idx;
  stack_op_e        stack_op;

  assign stack_op = stack_op_e'(bus.CONTEXT_I[O_SOP +: 2]);
  assign full     = (sp_q == PW'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IW'(sp_q);
  assign top_idx  = IW'(sp_q - 1'b1);

  // Stack effect on the regfile and pointer, before this cycle's writes.
  always_comb begin
    rf_base = rf_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_ok = 1'b0;
    case (stack_op)
      ST_PUSH: begin
        if (full) err_d = 1'b1;
        else begin
          push_ok = 1'b1;
          sp_d    = sp_q + 1'b1;
        end
      end
      ST_POP: begin
        if (empty) err_d = 1'b1;
        else begin
          rf_base = stack_q[top_idx];
          sp_d    = sp_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else if (bus.EN_I) begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // NOTE: snapshot storage has no reset; entries are only read after being pushed.
  always_ff @(posedge CLK_I) begin
    if (bus.EN_I && push_ok) stack_q[push_idx] <= rf_q;
  end

  assign bus.STACK_FULL_O  = full;
  assign bus.STACK_EMPTY_O = empty;
  assign bus.ERR_O         = err_q;
`else
  assign rf_base           = rf_q;
  assign bus.STACK_FULL_O  = 1'b0;
  assign bus.STACK_EMPTY_O = 1'b1;
  assign bus.ERR_O         = 1'b0;
`endif

  // Port B applied first so port A overrides it on an address clash.
  always_comb begin
    rf_d = rf_base;
    if (wr_en_b && (int'(waddr_b) < DEPTH)) rf_d[waddr_b] = in_b;
    if (wr_en_a && (int'(waddr_a) < DEPTH)) rf_d[waddr_a] = in_a;
  end

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I)       rf_q <= '0;
    else if (bus.EN_I)  rf_q <= rf_d;
  end
endmodule

// File: tb/tb_pbox_param.sv
// ---------------------------------------------------------------------------
// tb_pbox_param : directed self-checking bench for pbox_param.
//   dut  : NUM_STATUS=4, DEPTH=8 (main functional tests)
//   dut2 : NUM_STATUS=3, DEPTH=6 (out-of-range select/address tests)
//   Stack tests run when PBOX_STACK_EN is defined, stack-off tests otherwise.
// ---------------------------------------------------------------------------
module tb_pbox_param;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  pbox_param_if #(.NUM_STATUS(4), .DEPTH(8)) b1 ();
  pbox_param_if #(.NUM_STATUS(3), .DEPTH(6)) b2 ();

  pbox_param #(.NUM_STATUS(4), .DEPTH(8), .STACK_DEPTH(4)) dut (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (b1)
  );

  pbox_param #(.NUM_STATUS(3), .DEPTH(6), .STACK_DEPTH(4)) dut2 (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both instances use SW=2, AW=3, so one 24-bit layout serves both.
  function automatic logic [23:0] mk(input logic we_a, input logic we_b, input logic [1:0] sel,
                                     input logic [2:0] wa, input logic [2:0] wb,
                                     input logic [2:0] rc, input logic [2:0] ro,
                                     input logic [1:0] opa, input logic [1:0] opb,
                                     input logic [1:0] osel, input logic [1:0] sop);
    mk = {sop, osel, opb, opa, ro, rc, wb, wa, sel, we_b, we_a};
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write val to addr of dut: status bit0=1, bypass; A writes s=1, B writes ~s=0.
  task automatic wr(input logic [2:0] addr, input logic val, input logic [1:0] sop);
    b1.STATUS_I = 4'b0001;
    if (val) b1.CONTEXT_I = mk(1'b1, 1'b0, 2'd0, addr, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, sop);
    else     b1.CONTEXT_I = mk(1'b0, 1'b1, 2'd0, 3'd0, addr, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, sop);
    tick();
  endtask

  task automatic rd(input logic [2:0] addr, input logic exp, input string tag);
    b1.CONTEXT_I = mk(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, addr, 2'd0, 2'd0, 2'd2, 2'd0);
    #1;
    check(tag, b1.REG_O, exp);
  endtask

  task automatic stack_op(input logic [1:0] sop);
    b1.CONTEXT_I = mk(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, sop);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    b1.EN_I      = 1'b1;
    b1.STATUS_I  = '0;
    b1.CONTEXT_I = '0;
    b2.EN_I      = 1'b1;
    b2.STATUS_I  = '0;
    b2.CONTEXT_I = '0;
    do_reset();

    // Reset state
    #1;
    check("rst_reg_o",   b1.REG_O, 1'b0);
    check("rst_comb_o",  b1.COMB_O, 1'b0);
    check("rst_full",    b1.STACK_FULL_O, 1'b0);
    check("rst_empty",   b1.STACK_EMPTY_O, 1'b1);
    check("rst_err",     b1.ERR_O, 1'b0);

    // T2: r3=1, STATUS=0100, SEL=2 -> s=1, c=1
    wr(3'd3, 1'b1, 2'd0);
    b1.STATUS_I  = 4'b0100;
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd3, 3'd3, 2'b01, 2'b00, 2'd0, 2'd0);
    #1 check("t2_opa_and", b1.COMB_O, 1'b1);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd3, 3'd3, 2'b01, 2'b10, 2'd1, 2'd0);
    #1 check("t2_opb_or", b1.COMB_O, 1'b1);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd3, 3'd3, 2'b01, 2'b01, 2'd1, 2'd0);
    #1 check("t2_opb_and", b1.COMB_O, 1'b0);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd3, 3'd3, 2'b11, 2'b01, 2'd0, 2'd0);
    #1 check("t2_opa_xor", b1.COMB_O, 1'b0);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd3, 3'd3, 2'b11, 2'b01, 2'd3, 2'd0);
    #1 check("t2_osel_c", b1.COMB_O, 1'b1);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd3, 3'd3, 2'b11, 2'b01, 2'd2, 2'd0);
    #1 check("t2_osel_reg", b1.COMB_O, 1'b1);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd4, 3'd3, 2'b01, 2'b00, 2'd0, 2'd0);
    #1 check("t2_opa_and_c0", b1.COMB_O, 1'b0);
    b1.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd4, 3'd3, 2'b00, 2'b10, 2'd1, 2'd0);
    #1 check("t2_opb_or_c0", b1.COMB_O, 1'b0);
    @(negedge clk);

    // T3: both ports to r5, inA=1 inB=0 -> A wins
    b1.STATUS_I  = 4'b0100;
    b1.CONTEXT_I = mk(1, 1, 2'd2, 3'd5, 3'd5, 0, 3'd5, 2'b00, 2'b00, 2'd2, 2'd0);
    #1 check("t3_pre_write", b1.REG_O, 1'b0);
    tick();
    #1 check("t3_a_wins", b1.REG_O, 1'b1);
    // Same conflict with inA=0 inB=1, but disabled -> r5 holds
    b1.STATUS_I = 4'b0000;
    b1.EN_I     = 1'b0;
    tick();
    #1 check("t3_en_hold", b1.REG_O, 1'b1);
    b1.EN_I = 1'b1;
    tick();
    #1 check("t3_a_wins_zero", b1.REG_O, 1'b0);

    // Async reset mid-run, no clock edge in between
    wr(3'd1, 1'b1, 2'd0);
    rd(3'd1, 1'b1, "pre_async_rst");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_reg", b1.REG_O, 1'b0);
    check("async_rst_err", b1.ERR_O, 1'b0);
    check("async_rst_empty", b1.STACK_EMPTY_O, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd3, 1'b0, "async_rst_r3");

    // T4: dut2 with NUM_STATUS=3, DEPTH=6
    b2.STATUS_I  = 3'b111;
    b2.CONTEXT_I = mk(0, 0, 2'd3, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 2'd0);
    #1 check("t4_sel_oor", b2.COMB_O, 1'b0);
    b2.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 2'd0);
    #1 check("t4_sel_in", b2.COMB_O, 1'b1);
    b2.CONTEXT_I = mk(1, 0, 2'd2, 3'd5, 0, 0, 3'd5, 2'b00, 2'b00, 2'd0, 2'd0);
    tick();
    #1 check("t4_r5_written", b2.REG_O, 1'b1);
    b2.CONTEXT_I = mk(1, 0, 2'd2, 3'd7, 0, 0, 3'd7, 2'b00, 2'b00, 2'd0, 2'd0);
    tick();
    #1 check("t4_raddr_oor", b2.REG_O, 1'b0);
    b2.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd5, 0, 2'b00, 2'b00, 2'd3, 2'd0);
    #1 check("t4_c_r5", b2.COMB_O, 1'b1);
    b2.CONTEXT_I = mk(0, 0, 2'd2, 0, 0, 3'd6, 0, 2'b00, 2'b00, 2'd3, 2'd0);
    #1 check("t4_c_oor", b2.COMB_O, 1'b0);
    @(negedge clk);

`ifdef PBOX_STACK_EN
    // T5: regfile = 8'hA5, push, clear r0, pop restores
    do_reset();
    wr(3'd0, 1'b1, 2'd0);
    wr(3'd2, 1'b1, 2'd0);
    wr(3'd5, 1'b1, 2'd0);
    wr(3'd7, 1'b1, 2'd0);
    stack_op(2'd1);
    #1 check("t5_not_empty", b1.STACK_EMPTY_O, 1'b0);
    wr(3'd0, 1'b0, 2'd0);
    rd(3'd0, 1'b0, "t5_r0_cleared");
    stack_op(2'd2);
    rd(3'd0, 1'b1, "t5_pop_r0");
    rd(3'd7, 1'b1, "t5_pop_r7");
    rd(3'd1, 1'b0, "t5_pop_r1");
    check("t5_empty_again", b1.STACK_EMPTY_O, 1'b1);
    // Pop with a write to r2 in the same cycle: write wins over restore
    stack_op(2'd1);
    wr(3'd2, 1'b0, 2'd2);
    rd(3'd2, 1'b0, "t5_pop_write_r2");
    rd(3'd5, 1'b1, "t5_pop_write_r5");
    repeat (4) stack_op(2'd1);
    #1;
    check("t5_full", b1.STACK_FULL_O, 1'b1);
    check("t5_no_err_yet", b1.ERR_O, 1'b0);
    stack_op(2'd1);
    #1 check("t5_overflow_err", b1.ERR_O, 1'b1);
    rd(3'd0, 1'b1, "t5_overflow_r0");
    rd(3'd2, 1'b0, "t5_overflow_r2");
    do_reset();
    #1 check("t5_err_cleared", b1.ERR_O, 1'b0);
    stack_op(2'd2);
    #1;
    check("t5_underflow_err", b1.ERR_O, 1'b1);
    check("t5_underflow_empty", b1.STACK_EMPTY_O, 1'b1);
    rd(3'd0, 1'b0, "t5_underflow_r0");
`else
    // T6: stack ops ignored, flags constant, regfile only via writes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr(3'(i), 1'b1, (i % 2 == 0) ? 2'd1 : 2'd2);
      #1;
      check("t6_full", b1.STACK_FULL_O, 1'b0);
      check("t6_empty", b1.STACK_EMPTY_O, 1'b1);
      check("t6_err", b1.ERR_O, 1'b0);
    end
    rd(3'd3, 1'b1, "t6_r3");
    rd(3'd5, 1'b1, "t6_r5");
    rd(3'd6, 1'b0, "t6_r6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
